// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- RV32I instruction-fetch stage.
//
// Keeps the fetch PC and issues one word request at a time to instruction
// memory. Each fetched word goes to the decode stage together with its PC.
// A one-entry hold buffer absorbs a response that arrives while decode is
// stalled. Redirects from execute flush the stage. Bus errors and misaligned
// redirect targets are reported as fetch faults.
//
// Ports
//   clk_i            rising-edge clock
//   rst_i            synchronous active-high reset
//   imem_addr_o      fetch address (word aligned whenever imem_valid_o=1)
//   imem_valid_o     fetch request
//   imem_ready_i     memory accepts the request this cycle
//   imem_rdata_i     fetched word
//   imem_rvalid_i    response strobe, at least one cycle after acceptance
//   imem_error_i     bus fault, qualified by imem_rvalid_i
//   branch_taken_i   redirect from execute
//   branch_target_i  redirect address
//   id_stall_i       decode cannot accept; presented entry must hold
//   pc_o             PC of the entry presented to decode
//   instruction_o    instruction presented to decode
//   if_valid_o       presented entry is valid
//   if_exception_o   presented entry is a fetch fault
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_addr_o,
    output logic        imem_valid_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_rvalid_i,
    input  logic        imem_error_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        id_stall_i,
    output logic [31:0] pc_o,
    output logic [31:0] instruction_o,
    output logic        if_valid_o,
    output logic        if_exception_o
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_e;

    state_e      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] req_pc_q;
    logic        discard_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic        exc_q;
    logic [31:0] hold_pc_q;
    logic [31:0] hold_instr_q;

    logic slot_free;
    logic misaligned;
    logic pending_d;

    // The presented entry may be replaced when it is empty or being consumed.
    assign slot_free  = !valid_q || !id_stall_i;
    assign misaligned = (branch_target_i[1:0] != 2'b00);

    // A response is still owed to us after this cycle if one was outstanding
    // and has not arrived, or a request is being accepted right now. discard_q
    // is only ever set while a response is owed, which lets FAULT remember a
    // request that a misaligned redirect orphaned.
    assign pending_d = ((state_q == S_WAIT || discard_q) && !imem_rvalid_i)
                     || (state_q == S_REQ && imem_ready_i);

    assign imem_valid_o   = (state_q == S_REQ);
    assign imem_addr_o    = fetch_pc_q;
    assign pc_o           = pc_q;
    assign instruction_o  = instr_q;
    assign if_valid_o     = valid_q;
    assign if_exception_o = exc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_BOOT;
            fetch_pc_q <= RESET_ADDR;
            discard_q  <= 1'b0;
            pc_q       <= RESET_ADDR;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
            exc_q      <= 1'b0;
        end else if (state_q == S_BOOT) begin
            // Any response still in flight from before reset lands here and is ignored.
            state_q <= S_REQ;
        end else if (branch_taken_i) begin
            // Redirect outranks every other event this cycle.
            fetch_pc_q <= branch_target_i;
            discard_q  <= pending_d;
            instr_q    <= NOP_INSTR;
            if (misaligned) begin
                pc_q    <= branch_target_i;
                valid_q <= 1'b1;
                exc_q   <= 1'b1;
                state_q <= S_FAULT;
            end else begin
                valid_q <= 1'b0;
                exc_q   <= 1'b0;
                state_q <= pending_d ? S_WAIT : S_REQ;
            end
        end else begin
            // Default: a consumed or empty slot becomes a bubble, pc kept.
            if (slot_free) begin
                valid_q <= 1'b0;
                instr_q <= NOP_INSTR;
                exc_q   <= 1'b0;
            end
            case (state_q)
                S_REQ: begin
                    if (imem_ready_i) begin
                        req_pc_q   <= fetch_pc_q;
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (discard_q) begin
                            discard_q <= 1'b0;
                            state_q   <= S_REQ;
                        end else if (imem_error_i) begin
                            pc_q    <= req_pc_q;
                            instr_q <= NOP_INSTR;
                            valid_q <= 1'b1;
                            exc_q   <= 1'b1;
                            state_q <= S_FAULT;
                        end else if (slot_free) begin
                            pc_q    <= req_pc_q;
                            instr_q <= imem_rdata_i;
                            valid_q <= 1'b1;
                            state_q <= S_REQ;
                        end else begin
                            hold_pc_q    <= req_pc_q;
                            hold_instr_q <= imem_rdata_i;
                            state_q      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // The slot is always valid here, so only the stall matters.
                    if (!id_stall_i) begin
                        pc_q    <= hold_pc_q;
                        instr_q <= hold_instr_q;
                        valid_q <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_FAULT: begin
                    // Swallow the orphaned response, if any; only a redirect leaves.
                    if (imem_rvalid_i) begin
                        discard_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        imem_error;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_stall;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        if_valid;
    logic        if_exception;

    always #5 clk = ~clk;

    if_stage #(.RESET_ADDR(RESET_ADDR), .NOP_INSTR(NOP)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .imem_addr_o    (imem_addr),
        .imem_valid_o   (imem_valid),
        .imem_ready_i   (imem_ready),
        .imem_rdata_i   (imem_rdata),
        .imem_rvalid_i  (imem_rvalid),
        .imem_error_i   (imem_error),
        .branch_taken_i (branch_taken),
        .branch_target_i(branch_target),
        .id_stall_i     (id_stall),
        .pc_o           (pc),
        .instruction_o  (instruction),
        .if_valid_o     (if_valid),
        .if_exception_o (if_exception)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- memory model (stimulus side) ----------------
    int          ready_pct = 100;
    int          lat_min   = 1;
    int          lat_max   = 1;
    int          err_pct   = 0;
    bit          rnd_data  = 0;
    bit          mem_keep_on_rst = 0;
    logic [31:0] err_addr  = 32'hFFFF_FFFF;
    bit          mem_busy  = 0;
    int          mem_rem   = 0;
    logic [31:0] mem_addr  = 32'h0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0001e2b7;
            32'h0000_0004: return 32'h00001297;
            32'h0000_0008: return 32'h30d0106f;
            32'h0000_000C: return 32'h00f60863;
            32'h0000_0010: return 32'h04c6a023;
            32'h0000_1bec: return 32'h00c58533;
            default:       return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    // ---------------- behavioural reference ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;

    bit          m_boot, m_inflight, m_drop, m_faulted, m_v, m_x;
    logic [31:0] m_fetch_pc, m_req_pc, m_pc, m_ins;
    entry_t      m_buf[$];

    // What the stage should show after the coming clock edge, from the inputs now applied.
    task automatic model_step();
        bit     req, acc, resp, got_word, still;
        entry_t e;
        e = '0;
        if (rst) begin
            m_boot = 1; m_fetch_pc = RESET_ADDR; m_pc = RESET_ADDR; m_ins = NOP;
            m_v = 0; m_x = 0; m_inflight = 0; m_drop = 0; m_faulted = 0;
            m_buf.delete();
            return;
        end
        if (m_boot) begin
            m_boot = 0;
            return;
        end
        req  = !m_faulted && !m_inflight && (m_buf.size() == 0);
        acc  = req && imem_ready;
        resp = m_inflight && imem_rvalid;
        if (branch_taken) begin
            still = (m_inflight && !imem_rvalid) || acc;
            m_inflight = still;
            m_drop     = still;
            m_buf.delete();
            m_fetch_pc = branch_target;
            m_ins      = NOP;
            if (branch_target[1:0] != 2'b00) begin
                m_pc = branch_target; m_v = 1; m_x = 1; m_faulted = 1;
            end else begin
                m_v = 0; m_x = 0; m_faulted = 0;
            end
            return;
        end
        got_word = 0;
        if (acc) begin
            m_req_pc   = m_fetch_pc;
            m_fetch_pc = m_fetch_pc + 32'd4;
            m_inflight = 1;
        end
        if (resp) begin
            m_inflight = 0;
            if (m_drop) begin
                m_drop = 0;
            end else if (imem_error) begin
                m_pc = m_req_pc; m_ins = NOP; m_v = 1; m_x = 1; m_faulted = 1;
                return;
            end else begin
                e.pc = m_req_pc; e.ins = imem_rdata; got_word = 1;
            end
        end
        if (!m_v || !id_stall) begin
            if (m_buf.size() > 0) begin
                e = m_buf.pop_front();
                m_pc = e.pc; m_ins = e.ins; m_v = 1; m_x = 0;
            end else if (got_word) begin
                m_pc = e.pc; m_ins = e.ins; m_v = 1; m_x = 0;
            end else begin
                m_v = 0; m_ins = NOP; m_x = 0;
            end
        end else if (got_word) begin
            m_buf.push_back(e);
        end
    endtask

    // ---------------- logs of observed traffic ----------------
    logic [31:0] acc_log[$];
    logic [63:0] cons_log[$];

    function automatic logic [31:0] aget(input int i);
        if (i < acc_log.size()) return acc_log[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] cpc(input int i);
        logic [63:0] v;
        if (i >= cons_log.size()) return 32'hxxxx_xxxx;
        v = cons_log[i];
        return v[63:32];
    endfunction

    function automatic logic [31:0] cins(input int i);
        logic [63:0] v;
        if (i >= cons_log.size()) return 32'hxxxx_xxxx;
        v = cons_log[i];
        return v[31:0];
    endfunction

    // One clock: update the model, clock the DUT, compare, then update the memory side.
    task automatic tick();
        bit          acc, rsp;
        logic [31:0] acc_a;
        bit          exp_req;
        model_step();
        acc   = imem_valid && imem_ready && !rst;
        acc_a = imem_addr;
        rsp   = imem_rvalid;
        if (acc) acc_log.push_back(acc_a);
        if (if_valid && !id_stall && !rst) cons_log.push_back({pc, instruction});
        @(posedge clk);
        #1;
        exp_req = !m_boot && !m_faulted && !m_inflight && (m_buf.size() == 0);
        check("pc",         pc,                  m_pc);
        check("instr",      instruction,         m_ins);
        check("if_valid",   32'(if_valid),       32'(m_v));
        check("if_exc",     32'(if_exception),   32'(m_x));
        check("imem_valid", 32'(imem_valid),     32'(exp_req));
        check("imem_addr",  imem_addr,           m_fetch_pc);
        if (rst && !mem_keep_on_rst) mem_busy = 0;
        if (rsp) mem_busy = 0;
        else if (mem_busy) mem_rem--;
        if (acc) begin
            mem_busy = 1;
            mem_rem  = $urandom_range(lat_max, lat_min);
            mem_addr = acc_a;
        end
        imem_rvalid = mem_busy && (mem_rem == 1);
        imem_rdata  = rnd_data ? $urandom : (imem_rvalid ? memword(mem_addr) : 32'h0);
        if (rnd_data) imem_error = ($urandom_range(99) < err_pct);
        else imem_error = imem_rvalid && (mem_addr == err_addr);
        imem_ready = ($urandom_range(99) < ready_pct);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        branch_taken  = 1'b1;
        branch_target = tgt;
        tick();
        branch_taken  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0; imem_rvalid = 1'b0;
        imem_error = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; id_stall = 1'b0;
        m_boot = 1; m_inflight = 0; m_drop = 0; m_faulted = 0; m_v = 0; m_x = 0;
        m_fetch_pc = RESET_ADDR; m_req_pc = RESET_ADDR; m_pc = RESET_ADDR; m_ins = NOP;

        // 1: zero-wait memory after a two-cycle reset
        tick(); tick();
        check("rst_pc",    pc, RESET_ADDR);
        check("rst_instr", instruction, NOP);
        check("rst_valid", 32'(if_valid), 32'd0);
        rst = 1'b0;
        acc_log.delete(); cons_log.delete();
        repeat (8) tick();
        check("t1_req0", aget(0), 32'h0);
        check("t1_req1", aget(1), 32'h4);
        check("t1_req2", aget(2), 32'h8);
        check("t1_pc0",  cpc(0),  32'h0);
        check("t1_in0",  cins(0), 32'h0001e2b7);
        check("t1_pc1",  cpc(1),  32'h4);
        check("t1_in1",  cins(1), 32'h00001297);
        check("t1_pc2",  cpc(2),  32'h8);
        check("t1_in2",  cins(2), 32'h30d0106f);

        // 2: decode stall with a second word parked in the hold buffer
        acc_log.delete();
        tick();
        check("t2_first_pc", pc, 32'hC);
        id_stall = 1'b1;
        repeat (5) tick();
        check("t2_frozen_pc",  pc, 32'hC);
        check("t2_frozen_in",  instruction, 32'h00f60863);
        check("t2_frozen_vld", 32'(if_valid), 32'd1);
        check("t2_nreq",       32'(acc_log.size()), 32'd1);
        check("t2_req",        aget(0), 32'h10);
        id_stall = 1'b0;
        tick();
        check("t2_second_pc", pc, 32'h10);
        check("t2_second_in", instruction, 32'h04c6a023);

        // 3: redirect while a response is outstanding
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 10 && !(imem_valid && imem_ready); i++) tick();
        tick();
        check("t3_wait", 32'(imem_valid), 32'd0);
        redirect(32'h1bec);
        check("t3_flush", 32'(if_valid), 32'd0);
        lat_min = 1; lat_max = 1;
        acc_log.delete(); cons_log.delete();
        for (int i = 0; i < 20 && cons_log.size() == 0; i++) tick();
        check("t3_req", aget(0), 32'h1bec);
        check("t3_pc",  cpc(0),  32'h1bec);
        check("t3_in",  cins(0), 32'h00c58533);

        // 4: bus error on the fetch of 0x40
        err_addr = 32'h40;
        redirect(32'h40);
        for (int i = 0; i < 20 && !if_exception; i++) tick();
        check("t4_pc",  pc, 32'h40);
        check("t4_exc", 32'(if_exception), 32'd1);
        check("t4_in",  instruction, NOP);
        acc_log.delete();
        repeat (6) tick();
        check("t4_noreq", 32'(acc_log.size()), 32'd0);
        err_addr = 32'hFFFF_FFFF;
        redirect(32'h100);
        cons_log.delete();
        for (int i = 0; i < 20 && cons_log.size() == 0; i++) tick();
        check("t4_resume", cpc(0), 32'h100);

        // 5: misaligned target
        redirect(32'h102);
        acc_log.delete();
        check("t5_pc",  pc, 32'h102);
        check("t5_vld", 32'(if_valid), 32'd1);
        check("t5_exc", 32'(if_exception), 32'd1);
        repeat (4) tick();
        check("t5_noreq", 32'(acc_log.size()), 32'd0);
        redirect(32'h200);
        repeat (4) tick();

        // 6: PC wrap, then reset while waiting for a response
        redirect(32'hFFFF_FFFC);
        acc_log.delete();
        for (int i = 0; i < 20 && acc_log.size() < 2; i++) tick();
        check("t6_wrap0", aget(0), 32'hFFFF_FFFC);
        check("t6_wrap1", aget(1), 32'h0);
        lat_min = 3; lat_max = 3;
        acc_log.delete();
        for (int i = 0; i < 20 && acc_log.size() == 0; i++) tick();
        mem_keep_on_rst = 1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("t6_late_rvalid", 32'(imem_rvalid), 32'd1);
        tick();
        check("t6_pc",  pc, RESET_ADDR);
        check("t6_vld", 32'(if_valid), 32'd0);
        mem_keep_on_rst = 0;
        lat_min = 1; lat_max = 1;
        cons_log.delete();
        for (int i = 0; i < 20 && cons_log.size() == 0; i++) tick();
        check("t6_restart", cpc(0), RESET_ADDR);

        // Randomized traffic against the reference
        ready_pct = 60; lat_min = 1; lat_max = 4; err_pct = 4; rnd_data = 1;
        for (int n = 0; n < 3000; n++) begin
            id_stall     = ($urandom_range(99) < 30);
            rst          = ($urandom_range(299) == 0);
            branch_taken = ($urandom_range(99) < 6);
            case ($urandom_range(9))
                0:       branch_target = $urandom | 32'h1;
                1:       branch_target = 32'hFFFF_FFF8;
                default: branch_target = $urandom & 32'hFFFF_FFFC;
            endcase
            tick();
        end
        rst = 1'b0; branch_taken = 1'b0; id_stall = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
